// File: rtl/req_gen_if.sv
// req_gen_if: valid-qualified pointer bus from the request generator.
// master drives the pointer stream, slave consumes it.
interface req_gen_if #(
    parameter int PTR_W = 4
);
    logic [PTR_W-1:0] out_ptr;
    logic             out_ptr_vld;

    modport master (
        output out_ptr,
        output out_ptr_vld
    );

    modport slave (
        input out_ptr,
        input out_ptr_vld
    );
endinterface

// File: rtl/req_gen.sv
// req_gen: free-running generator of bursty, valid-qualified list pointers.
// Define REQ_GEN_LFSR_EN to step pointers with a Galois LFSR instead of a stride.
module req_gen #(
    parameter int PTR_W     = 4,
    parameter int HEAD      = 0,
    parameter int STRIDE    = 5,
    parameter int BURST_LEN = 4,
    parameter int IDLE_LEN  = 2,
    parameter int NUM_REQ   = 0,
    parameter logic [PTR_W-1:0] LFSR_TAPS = PTR_W'(4'b1100)
) (
    input  logic      clk,
    input  logic      rst,
    req_gen_if.master req
);

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [1:0] {
        ST_START,
        ST_BURST,
        ST_IDLE,
        ST_DONE
    } state_t;

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int IW = (IDLE_LEN < 1) ? 1 : $clog2(IDLE_LEN + 1);
    localparam int RW = (NUM_REQ < 1) ? 1 : $clog2(NUM_REQ + 1);

    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [IW-1:0] IDLE_LAST =
        IW'((IDLE_LEN < 1) ? 0 : IDLE_LEN - 1);
    localparam logic [RW-1:0] REQ_LAST =
        RW'((NUM_REQ < 1) ? 0 : NUM_REQ - 1);

    localparam ptr_t HEAD_P = ptr_t'(HEAD);
    localparam ptr_t STEP   = ptr_t'(STRIDE);

`ifdef REQ_GEN_LFSR_EN
    // The all-zero LFSR state locks up, so a zero head is replaced by 1.
    localparam ptr_t SEED = (HEAD_P == '0) ? ptr_t'(1) : HEAD_P;
`else
    localparam ptr_t SEED = HEAD_P;
`endif

    state_t          state_q, state_d;
    ptr_t            ptr_q, ptr_d;
    logic            vld_q, vld_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [RW-1:0]   req_q, req_d;
    logic            burst_done;
    logic            idle_done;
    logic            req_done;
    logic            req_sat;

    function automatic ptr_t step(input ptr_t p);
`ifdef REQ_GEN_LFSR_EN
        step = (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
`else
        step = p + STEP;
`endif
    endfunction

    // Terminal-count flags for burst, idle and request counters.
    always_comb begin
        burst_done = (burst_q == BURST_LAST);
        idle_done  = (idle_q == IDLE_LAST);
        req_done   = (NUM_REQ != 0) && (req_q == REQ_LAST);
        req_sat    = (req_q == '1);
    end

    // State and registered outputs, synchronous reset restarts from the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_START;
            ptr_q   <= SEED;
            vld_q   <= 1'b0;
            burst_q <= '0;
            idle_q  <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
            req_q   <= req_d;
        end
    end

    // Next state: request limit wins over burst/idle sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_START: state_d = ST_BURST;
            ST_BURST: begin
                if (req_done) begin
                    state_d = ST_DONE;
                end else if (burst_done && (IDLE_LEN != 0)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (idle_done) begin
                    state_d = ST_BURST;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_START;
        endcase
    end

    // Next outputs and counters; pointer advances once per sent request.
    always_comb begin
        ptr_d   = ptr_q;
        vld_d   = 1'b0;
        burst_d = burst_q;
        idle_d  = idle_q;
        req_d   = req_q;
        unique case (state_q)
            ST_START: begin
                vld_d   = 1'b1;
                burst_d = '0;
                idle_d  = '0;
            end
            ST_BURST: begin
                ptr_d   = step(ptr_q);
                req_d   = req_sat ? req_q : req_q + RW'(1);
                burst_d = burst_done ? '0 : burst_q + BW'(1);
                idle_d  = '0;
                vld_d   = (state_d == ST_BURST);
            end
            ST_IDLE: begin
                vld_d  = (state_d == ST_BURST);
                idle_d = idle_done ? '0 : idle_q + IW'(1);
            end
            ST_DONE: begin
                vld_d = 1'b0;
            end
            default: begin
                vld_d = 1'b0;
            end
        endcase
    end

    assign req.out_ptr     = ptr_q;
    assign req.out_ptr_vld = vld_q;

endmodule

// File: tb/tb_req_gen.sv
// tb_req_gen: checks req_gen against a closed-form stream model.
// Three instances: defaults, NUM_REQ=6, IDLE_LEN=0; honours REQ_GEN_LFSR_EN.
module tb_req_gen;

    localparam int W = 4;
    localparam int M = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    req_gen_if #(.PTR_W(W)) if_def ();
    req_gen_if #(.PTR_W(W)) if_nr ();
    req_gen_if #(.PTR_W(W)) if_cont ();

    req_gen #(.PTR_W(W)) u_def (
        .clk(clk),
        .rst(rst),
        .req(if_def)
    );

    req_gen #(.PTR_W(W), .NUM_REQ(6)) u_nr (
        .clk(clk),
        .rst(rst),
        .req(if_nr)
    );

    req_gen #(.PTR_W(W), .IDLE_LEN(0)) u_cont (
        .clk(clk),
        .rst(rst),
        .req(if_cont)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int seed_of(input int head);
`ifdef REQ_GEN_LFSR_EN
        return (head % M == 0) ? 1 : head % M;
`else
        return head % M;
`endif
    endfunction

    // Pointer carried after r requests have been sent.
    function automatic int ptr_after(input int head,
                                     input int stride,
                                     input int r);
`ifdef REQ_GEN_LFSR_EN
        int p;
        p = seed_of(head);
        for (int i = 0; i < r; i++) begin
            p = (p >> 1) ^ (((p & 1) != 0) ? 12 : 0);
        end
        return p;
`else
        return (head + r * stride) % M;
`endif
    endfunction

    // n = edges since reset released; cycle m = n-1 of a bl-on/il-off
    // pattern, with r requests already sent, capped at nr.
    function automatic void model(input int n, input int bl,
                                  input int il, input int nr,
                                  output int v, output int p);
        int m, per, pos, r;
        if (n == 0) begin
            v = 0;
            p = seed_of(0);
            return;
        end
        m   = n - 1;
        per = m / (bl + il);
        pos = m % (bl + il);
        r   = per * bl + ((pos < bl) ? pos : bl);
        v   = (pos < bl) ? 1 : 0;
        if (nr != 0 && r >= nr) begin
            v = 0;
            r = nr;
        end
        p = ptr_after(0, 5, r);
    endfunction

    int n = 0;
    bit armed = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            n     <= 0;
            armed <= 1'b1;
        end else begin
            n <= n + 1;
        end
    end

    int ev, ep;
    int def_cnt = 0;
    int nr_cnt = 0;
    int cont_cnt = 0;
    int zero_cnt = 0;
    logic [W-1:0] def_q[$];

    always @(negedge clk) begin
        if (armed) begin
            model(n, 4, 2, 0, ev, ep);
            check("def_vld", if_def.out_ptr_vld, ev);
            check("def_ptr", if_def.out_ptr, ep);
            model(n, 4, 2, 6, ev, ep);
            check("nr_vld", if_nr.out_ptr_vld, ev);
            check("nr_ptr", if_nr.out_ptr, ep);
            model(n, 4, 0, 0, ev, ep);
            check("cont_vld", if_cont.out_ptr_vld, ev);
            check("cont_ptr", if_cont.out_ptr, ep);
            if (if_def.out_ptr_vld === 1'b1) begin
                def_cnt++;
                def_q.push_back(if_def.out_ptr);
                if (if_def.out_ptr == 0) zero_cnt++;
            end
            if (if_nr.out_ptr_vld === 1'b1) begin
                nr_cnt++;
                if (if_nr.out_ptr == 0) zero_cnt++;
            end
            if (if_cont.out_ptr_vld === 1'b1) begin
                cont_cnt++;
                if (if_cont.out_ptr == 0) zero_cnt++;
            end
        end
    end

    int lit[10];
    int idx[10];
    int nr_end;
    int cont_end;
    int got;
    int found;
    logic [W-1:0] last;

    initial begin
        idx = '{0, 1, 2, 3, 4, 5, 6, 7, 15, 16};
`ifdef REQ_GEN_LFSR_EN
        lit = '{1, 12, 6, 3, 13, 10, 5, 14, 1, 12};
        nr_end = 5;
        cont_end = 13;
`else
        lit = '{0, 5, 10, 15, 4, 9, 14, 3, 11, 0};
        nr_end = 14;
        cont_end = 5;
`endif

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", if_def.out_ptr_vld, 0);
        rst = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        #2;

        check("def_valid_count", def_cnt, 34);
        check("nr_valid_count", nr_cnt, 6);
        check("cont_valid_count", cont_cnt, 50);
        if (def_q.size() >= 17) begin
            for (int i = 0; i < 10; i++) begin
                check($sformatf("def_valid_%0d", idx[i]),
                      def_q[idx[i]], lit[i]);
            end
        end else begin
            check("def_queue_len", def_q.size(), 17);
        end
        check("nr_end_vld", if_nr.out_ptr_vld, 0);
        check("nr_end_ptr", if_nr.out_ptr, nr_end);
        check("cont_end_ptr", if_cont.out_ptr, cont_end);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        got = 0;
        last = '0;
        for (int i = 0; i < 10 && got < 2; i++) begin
            @(negedge clk);
            #2;
            if (if_def.out_ptr_vld === 1'b1) begin
                got++;
                last = if_def.out_ptr;
            end
        end
        check("midrst_reach", got, 2);
        check("midrst_2nd_ptr", last, lit[1]);

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2;
        check("midrst_vld_drop", if_def.out_ptr_vld, 0);
        check("midrst_ptr_head", if_def.out_ptr, lit[0]);
        rst = 1'b0;
        found = -1;
        for (int i = 0; i < 10 && found < 0; i++) begin
            @(negedge clk);
            #2;
            if (if_def.out_ptr_vld === 1'b1) begin
                found = i;
                last = if_def.out_ptr;
            end
        end
        check("restart_latency", found, 0);
        check("restart_ptr", last, lit[0]);
        repeat (3) @(negedge clk);

`ifdef REQ_GEN_LFSR_EN
        check("lfsr_no_zero", zero_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
